// File: rtl/arith_pckg.sv
// Shared constants and types for the arithmetic datapath blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arith_pckg;

    localparam int C_ARITH_WORD_LEN = 16;

    // Result-sink FSM: waiting for a first operand, measuring pipe latency, streaming
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        RUN  = 2'd2
    } arith_sink_st_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, WIDTH x DEPTH, with full/empty tracked by an extra pointer bit.
// Latency: a written word is visible on rd_data one cycle after the write.
// Backpressure: writes are ignored when full unless a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Same index with differing wrap bits means the writer has lapped the reader
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Head word is forced to zero when nothing is buffered so stale data never leaks out
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage array; no reset needed since reads are gated by empty
    always_ff @(posedge clk) begin
        if (do_wr && !clr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update; clear wins over any simultaneous read or write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/arith_res_sink.sv
// Collects arithmetic-pipe results: buffers them, counts/signs them, measures first-result latency.
// Latency: a result appears on out_data/out_val one cycle after res_val.
// Backpressure: out_val/out_rdy handshake; a result arriving while full without a pop is dropped and flagged.
module arith_res_sink
    import arith_pckg::*;
#(
    parameter int WORD_LEN   = C_ARITH_WORD_LEN,
    parameter int FIFO_DEPTH = 8,
    parameter int LAT_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic                clr,
    input  logic                op_val_mon,
    input  logic [WORD_LEN-1:0] res,
    input  logic                res_val,
    output logic [WORD_LEN-1:0] out_data,
    output logic                out_val,
    input  logic                out_rdy,
    output logic [31:0]         res_cnt,
    output logic [WORD_LEN-1:0] sig,
    output logic [LAT_W-1:0]    lat,
    output logic                lat_val,
    output logic                ovf_err
);

    arith_sink_st_t   state;
    logic [LAT_W-1:0] lat_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push;
    logic             drop;
    logic             fifo_clr;
    logic             fifo_wr;
    logic             fifo_rd;

    assign out_val = !fifo_empty;
    assign pop     = out_val && out_rdy;
    // A full FIFO can still take a word when the head leaves in the same cycle
    assign push    = res_val && (!fifo_full || pop);
    assign drop    = res_val && fifo_full && !pop;

    // Everything the FIFO sees is qualified by clk_en so it holds along with the rest of the block
    assign fifo_clr = clk_en && clr;
    assign fifo_wr  = clk_en && !clr && push;
    assign fifo_rd  = clk_en && !clr && pop;

    sync_fifo #(
        .WIDTH (WORD_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (fifo_clr),
        .wr_en   (fifo_wr),
        .wr_data (res),
        .rd_en   (fifo_rd),
        .rd_data (out_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Result statistics: count, rotate-XOR signature and sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt <= '0;
            sig     <= '0;
            ovf_err <= 1'b0;
        end else if (clk_en) begin
            if (clr) begin
                res_cnt <= '0;
                sig     <= '0;
                ovf_err <= 1'b0;
            end else begin
                if (res_val) begin
                    res_cnt <= res_cnt + 32'd1;
                    sig     <= {sig[WORD_LEN-2:0], sig[WORD_LEN-1]} ^ res;
                end
                if (drop) begin
                    ovf_err <= 1'b1;
                end
            end
        end
    end

    // Latency FSM: first op_val_mon starts the count, first result after that latches it once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lat_cnt <= '0;
            lat     <= '0;
            lat_val <= 1'b0;
        end else if (clk_en) begin
            if (clr) begin
                state   <= IDLE;
                lat_cnt <= '0;
                lat     <= '0;
                lat_val <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (op_val_mon) begin
                            if (res_val) begin
                                // Result emerged in the same cycle as the operand
                                state   <= RUN;
                                lat     <= '0;
                                lat_val <= 1'b1;
                            end else begin
                                state   <= MEAS;
                                lat_cnt <= LAT_W'(1);
                            end
                        end
                    end
                    MEAS: begin
                        if (res_val) begin
                            state   <= RUN;
                            lat     <= lat_cnt;
                            lat_val <= 1'b1;
                        end else if (lat_cnt != '1) begin
                            lat_cnt <= lat_cnt + LAT_W'(1);
                        end
                    end
                    RUN: begin
                        // Measurement is one-shot; only clr or reset leaves this state
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_arith_res_sink.sv
// Directed bench for arith_res_sink (WORD_LEN=16, FIFO_DEPTH=8).
// Latency: inputs driven 1ns after a rising edge, outputs checked 1ns after the next one.
// Backpressure: out_rdy driven directly per scenario.
module tb_arith_res_sink;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        clr;
    logic        op_val_mon;
    logic [15:0] res;
    logic        res_val;
    logic [15:0] out_data;
    logic        out_val;
    logic        out_rdy;
    logic [31:0] res_cnt;
    logic [15:0] sig;
    logic [15:0] lat;
    logic        lat_val;
    logic        ovf_err;

    int chk_cnt = 0;
    int err_cnt = 0;

    arith_res_sink #(
        .WORD_LEN   (16),
        .FIFO_DEPTH (8),
        .LAT_W      (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .clr        (clr),
        .op_val_mon (op_val_mon),
        .res        (res),
        .res_val    (res_val),
        .out_data   (out_data),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .res_cnt    (res_cnt),
        .sig        (sig),
        .lat        (lat),
        .lat_val    (lat_val),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        clk_en     = 1'b1;
        clr        = 1'b0;
        op_val_mon = 1'b0;
        res        = 16'h0;
        res_val    = 1'b0;
        out_rdy    = 1'b0;

        // Reset state
        #12;
        chk("rst_out_val", {31'd0, out_val}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_res_cnt", res_cnt, 32'd0);
        chk("rst_sig", {16'd0, sig}, 32'd0);
        chk("rst_lat", {16'd0, lat}, 32'd0);
        chk("rst_lat_val", {31'd0, lat_val}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Latency measurement: operand at cycle 0, result at cycle 5
        op_val_mon = 1'b1;
        tick();
        op_val_mon = 1'b0;
        repeat (4) tick();
        chk("meas_lat_val_early", {31'd0, lat_val}, 32'd0);
        res_val = 1'b1;
        res     = 16'h00AA;
        tick();
        res_val = 1'b0;
        chk("meas_lat", {16'd0, lat}, 32'd5);
        chk("meas_lat_val", {31'd0, lat_val}, 32'd1);
        chk("meas_out_data", {16'd0, out_data}, 32'h00AA);
        chk("meas_sig", {16'd0, sig}, 32'h00AA);
        // Another operand in RUN must not disturb the latched latency
        op_val_mon = 1'b1;
        tick();
        op_val_mon = 1'b0;
        repeat (3) tick();
        chk("run_lat_hold", {16'd0, lat}, 32'd5);
        do_clr();
        chk("clr_out_val", {31'd0, out_val}, 32'd0);
        chk("clr_res_cnt", res_cnt, 32'd0);
        chk("clr_lat_val", {31'd0, lat_val}, 32'd0);
        chk("clr_lat", {16'd0, lat}, 32'd0);
        chk("clr_sig", {16'd0, sig}, 32'd0);

        // FIFO order with out_rdy=1: 1,2,3 stream straight through
        out_rdy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            res_val = 1'b1;
            res     = 16'(i);
            tick();
            chk("ord_out_val", {31'd0, out_val}, 32'd1);
            chk("ord_out_data", {16'd0, out_data}, 32'(i));
        end
        res_val = 1'b0;
        tick();
        chk("ord_empty", {31'd0, out_val}, 32'd0);
        // 0 -> 1 ; rol(1)^2 = 0 ; rol(0)^3 = 3
        chk("ord_sig", {16'd0, sig}, 32'h0003);
        chk("ord_res_cnt", res_cnt, 32'd3);
        chk("ord_idle_lat_val", {31'd0, lat_val}, 32'd0);
        do_clr();

        // Overflow: 9 results with no pops
        out_rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            res_val = 1'b1;
            res     = 16'h0010 + 16'(i);
            tick();
            if (i == 7) chk("ovf_before_9th", {31'd0, ovf_err}, 32'd0);
        end
        res_val = 1'b0;
        chk("ovf_flag", {31'd0, ovf_err}, 32'd1);
        chk("ovf_res_cnt", res_cnt, 32'd9);
        repeat (2) tick();
        chk("ovf_hold_data", {16'd0, out_data}, 32'h0010);
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain_val", {31'd0, out_val}, 32'd1);
            chk("ovf_drain_data", {16'd0, out_data}, 32'h0010 + 32'(i));
            tick();
        end
        chk("ovf_9th_absent", {31'd0, out_val}, 32'd0);
        chk("ovf_sticky", {31'd0, ovf_err}, 32'd1);
        do_clr();
        chk("ovf_clr", {31'd0, ovf_err}, 32'd0);

        // Full FIFO with simultaneous push and pop for 4 cycles
        out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            res_val = 1'b1;
            res     = 16'h0020 + 16'(i);
            tick();
        end
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            res_val = 1'b1;
            res     = 16'h0030 + 16'(i);
            chk("pp_head", {16'd0, out_data}, 32'h0020 + 32'(i));
            tick();
        end
        res_val = 1'b0;
        chk("pp_ovf", {31'd0, ovf_err}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("pp_drain", {16'd0, out_data},
                (i < 4) ? 32'h0024 + 32'(i) : 32'h0030 + 32'(i - 4));
            tick();
        end
        chk("pp_occupancy8", {31'd0, out_val}, 32'd0);
        chk("pp_res_cnt", res_cnt, 32'd12);
        do_clr();

        // Clock enable low for 3 cycles during measurement
        out_rdy    = 1'b0;
        op_val_mon = 1'b1;
        tick();
        op_val_mon = 1'b0;
        repeat (2) tick();
        clk_en  = 1'b0;
        res_val = 1'b1;
        res     = 16'h0055;
        repeat (3) tick();
        chk("cen_res_cnt_hold", res_cnt, 32'd0);
        chk("cen_lat_val_hold", {31'd0, lat_val}, 32'd0);
        chk("cen_out_val_hold", {31'd0, out_val}, 32'd0);
        clk_en = 1'b1;
        tick();
        res_val = 1'b0;
        chk("cen_lat", {16'd0, lat}, 32'd3);
        chk("cen_lat_val", {31'd0, lat_val}, 32'd1);
        chk("cen_res_cnt", res_cnt, 32'd1);
        chk("cen_sig", {16'd0, sig}, 32'h0055);
        do_clr();

        // Asynchronous reset mid-stream with 4 words buffered
        for (int i = 0; i < 4; i++) begin
            res_val = 1'b1;
            res     = 16'h0040 + 16'(i);
            tick();
        end
        res_val = 1'b0;
        chk("ar_pre_val", {31'd0, out_val}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_val", {31'd0, out_val}, 32'd0);
        chk("ar_out_data", {16'd0, out_data}, 32'd0);
        chk("ar_res_cnt", res_cnt, 32'd0);
        chk("ar_sig", {16'd0, sig}, 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        clr     = 1'b1;
        res_val = 1'b1;
        res     = 16'h0066;
        tick();
        clr     = 1'b0;
        res_val = 1'b0;
        chk("ar_clr_res_cnt", res_cnt, 32'd0);
        chk("ar_clr_out_val", {31'd0, out_val}, 32'd0);
        res_val = 1'b1;
        res     = 16'h0077;
        tick();
        res_val = 1'b0;
        chk("ar_resume_data", {16'd0, out_data}, 32'h0077);
        chk("ar_resume_cnt", res_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
